// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | uart_rx_fifo : edge-detected UART byte capture into a circular FIFO with
// |                registered read port and sticky overrun flag.  Rev 1.0
// +----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_done,
  input  logic                     rd_en,
  input  logic                     clr_overrun,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rx_done_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overrun_q, overrun_d;

  logic w_empty, w_full, w_wr_evt, w_rd_acc, w_wr_acc, w_ovf_evt;

  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == C_DEPTH);
  assign w_wr_evt  = rx_done & ~rx_done_q;
  assign w_rd_acc  = rd_en & ~w_empty;
  // A read in the same cycle frees the slot, so a write at full still lands.
  assign w_wr_acc  = w_wr_evt & (~w_full | w_rd_acc);
  assign w_ovf_evt = w_wr_evt & w_full & ~w_rd_acc;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overrun_d  = overrun_q;

    if (w_wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_rd_acc) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      rd_data_d  = mem[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    if (w_wr_acc && !w_rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      count_d = count_q - CW'(1);
    end

    if (w_ovf_evt) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_done_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_done_q  <= rx_done;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage is never reset; only entries that were written are ever read out.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = count_q;
  assign overrun  = overrun_q;

endmodule
`default_nettype wire
